// File: rtl/alu_pipe_if.sv
// Issue/writeback handshake bundle for alu_pipe.
// The master is the issue side: it offers operations and drains results.
interface alu_pipe_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] operand1;
  logic [WIDTH-1:0] operand2;
  logic [3:0]       alu_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero_flag;
  logic             neg_flag;
  logic             carry_flag;
  logic             ovf_flag;
  logic             illegal_op;
  logic             busy;

  modport master (
    output in_valid, operand1, operand2, alu_op, out_ready,
    input  in_ready, out_valid, result, zero_flag, neg_flag, carry_flag,
           ovf_flag, illegal_op, busy
  );

  modport slave (
    input  in_valid, operand1, operand2, alu_op, out_ready,
    output in_ready, out_valid, result, zero_flag, neg_flag, carry_flag,
           ovf_flag, illegal_op, busy
  );
endinterface

// File: rtl/alu_pipe.sv
// Handshaked ALU with a registered output stage and an iterative
// shift-add multiplier. Opcodes 0-7 match the legacy 3-bit ALU.
module alu_pipe #(
  parameter int WIDTH  = 32,
  parameter bit MUL_EN = 1'b1
) (
  input  logic      clk,
  input  logic      rst,
  alu_pipe_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] LAST_STEP = SHW'(WIDTH - 1);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_NAND = 4'd5;
  localparam logic [3:0] OP_NOR  = 4'd6;
  localparam logic [3:0] OP_XNOR = 4'd7;
  localparam logic [3:0] OP_SLL  = 4'd8;
  localparam logic [3:0] OP_SRL  = 4'd9;
  localparam logic [3:0] OP_SRA  = 4'd10;
  localparam logic [3:0] OP_SLT  = 4'd11;
  localparam logic [3:0] OP_SLTU = 4'd12;
  localparam logic [3:0] OP_MUL  = 4'd13;

  typedef enum logic [1:0] {IDLE, FULL, BUSY} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             carry;
    logic             ovf;
    logic             ill;
  } alu_out_t;

  // Single-cycle operations. MUL never reaches here when the multiplier
  // exists, so opcode 13 falls into the illegal branch only when disabled.
  function automatic alu_out_t alu_eval(input logic [3:0] op,
                                        input logic [WIDTH-1:0] a,
                                        input logic [WIDTH-1:0] b);
    alu_out_t                o;
    logic [WIDTH:0]          wide;
    logic signed [WIDTH-1:0] a_s;
    logic signed [WIDTH-1:0] b_s;
    logic [SHW-1:0]          amt;
    o    = '0;
    wide = '0;
    a_s  = $signed(a);
    b_s  = $signed(b);
    amt  = b[SHW-1:0];
    case (op)
      OP_ADD: begin
        wide    = {1'b0, a} + {1'b0, b};
        o.res   = wide[WIDTH-1:0];
        o.carry = wide[WIDTH];
        o.ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (o.res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        wide    = {1'b0, a} - {1'b0, b};
        o.res   = wide[WIDTH-1:0];
        o.carry = wide[WIDTH];
        o.ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (o.res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  o.res = a & b;
      OP_OR:   o.res = a | b;
      OP_XOR:  o.res = a ^ b;
      OP_NAND: o.res = ~(a & b);
      OP_NOR:  o.res = ~(a | b);
      OP_XNOR: o.res = ~(a ^ b);
      OP_SLL:  o.res = a << amt;
      OP_SRL:  o.res = a >> amt;
      OP_SRA:  o.res = $unsigned(a_s >>> amt);
      OP_SLT:  o.res = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
      OP_SLTU: o.res = {{(WIDTH-1){1'b0}}, (a < b)};
      default: o.ill = 1'b1;
    endcase
    return o;
  endfunction

  state_t           state;
  logic [SHW-1:0]   cnt;
  logic             in_ready_i;
  logic             accept_p0;
  logic             is_mul_p0;
  alu_out_t         eval_p0;
  logic [WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_nxt;
  logic [WIDTH:0]   step_sum;
  logic [WIDTH-1:0] res_p1;
  logic             zero_p1;
  logic             neg_p1;
  logic             carry_p1;
  logic             ovf_p1;
  logic             ill_p1;

  // Stage p0: issue handshake and single-cycle evaluation
  always_comb begin
    in_ready_i = !rst && ((state == IDLE) || ((state == FULL) && bus.out_ready));
  end

  assign accept_p0 = bus.in_valid && in_ready_i;
  assign is_mul_p0 = MUL_EN && (bus.alu_op == OP_MUL);
  assign eval_p0   = alu_eval(bus.alu_op, bus.operand1, bus.operand2);

  // One shift-add step: add the multiplicand into the high half when the
  // current multiplier bit is set, then shift the whole product right.
  always_comb begin
    step_sum = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
    prod_nxt = {step_sum, prod[WIDTH-1:1]};
  end

  // Multiplier datapath: load on MUL accept, step while BUSY
  always_ff @(posedge clk) begin
    if (accept_p0 && is_mul_p0) begin
      mcand <= bus.operand1;
      prod  <= {{WIDTH{1'b0}}, bus.operand2};
    end else if (state == BUSY) begin
      prod <= prod_nxt;
    end
  end

  // Stage p1: control FSM and registered result/flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      res_p1   <= '0;
      zero_p1  <= 1'b0;
      neg_p1   <= 1'b0;
      carry_p1 <= 1'b0;
      ovf_p1   <= 1'b0;
      ill_p1   <= 1'b0;
    end else begin
      unique case (state)
        IDLE, FULL: begin
          if (accept_p0) begin
            if (is_mul_p0) begin
              state <= BUSY;
              cnt   <= '0;
            end else begin
              state    <= FULL;
              res_p1   <= eval_p0.res;
              zero_p1  <= (eval_p0.res == '0);
              neg_p1   <= eval_p0.res[WIDTH-1];
              carry_p1 <= eval_p0.carry;
              ovf_p1   <= eval_p0.ovf;
              ill_p1   <= eval_p0.ill;
            end
          end else if ((state == FULL) && bus.out_ready) begin
            state <= IDLE;
          end
        end
        BUSY: begin
          cnt <= cnt + SHW'(1);
          if (cnt == LAST_STEP) begin
            state    <= FULL;
            res_p1   <= prod_nxt[WIDTH-1:0];
            zero_p1  <= (prod_nxt[WIDTH-1:0] == '0);
            neg_p1   <= prod_nxt[WIDTH-1];
            carry_p1 <= |prod_nxt[2*WIDTH-1:WIDTH];
            ovf_p1   <= 1'b0;
            ill_p1   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready   = in_ready_i;
  assign bus.out_valid  = (state == FULL);
  assign bus.busy       = (state == BUSY);
  assign bus.result     = res_p1;
  assign bus.zero_flag  = zero_p1;
  assign bus.neg_flag   = neg_p1;
  assign bus.carry_flag = carry_p1;
  assign bus.ovf_flag   = ovf_p1;
  assign bus.illegal_op = ill_p1;
endmodule

// File: tb/tb_alu_pipe.sv
// Randomised and directed bench for alu_pipe against a queue-based model.
module tb_alu_pipe;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  bit   chk_en = 1'b0;
  int   ordy_mode = 1;

  alu_pipe_if #(.WIDTH(W)) bus ();
  alu_pipe_if #(.WIDTH(W)) bus0 ();

  alu_pipe #(.WIDTH(W), .MUL_EN(1'b1)) u_dut (.clk(clk), .rst(rst), .bus(bus));
  alu_pipe #(.WIDTH(W), .MUL_EN(1'b0)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    logic z, n, c, v, ill;
    int due;
  } exp_t;

  exp_t q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected outcome of one operation, from plain 64-bit arithmetic.
  function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    longint sa, sb, sr;
    logic [63:0] ua, ub, t;
    int amt;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    amt = int'(b[4:0]);
    e.res = 32'd0; e.z = 1'b0; e.n = 1'b0; e.c = 1'b0; e.v = 1'b0; e.ill = 1'b0; e.due = 0;
    case (op)
      4'd0: begin
        t = ua + ub; e.res = t[31:0]; e.c = t[32];
        sr = sa + sb; e.v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      4'd1: begin
        e.res = a - b; e.c = (ua < ub);
        sr = sa - sb; e.v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      4'd2: e.res = a & b;
      4'd3: e.res = a | b;
      4'd4: e.res = a ^ b;
      4'd5: e.res = ~(a & b);
      4'd6: e.res = ~(a | b);
      4'd7: e.res = ~(a ^ b);
      4'd8: e.res = a << amt;
      4'd9: e.res = a >> amt;
      4'd10: e.res = (a >> amt) | (a[31] ? ~(32'hFFFF_FFFF >> amt) : 32'h0);
      4'd11: e.res = (sa < sb) ? 32'd1 : 32'd0;
      4'd12: e.res = (ua < ub) ? 32'd1 : 32'd0;
      4'd13: begin
        t = ua * ub; e.res = t[31:0]; e.c = (t[63:32] != 32'd0);
      end
      default: e.ill = 1'b1;
    endcase
    e.z = (e.res == 32'd0);
    e.n = e.res[31];
    return e;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // out_ready driver: 0 random, 1 held high, 2 held low
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ordy_mode)
        0: bus.out_ready = ($urandom_range(0, 9) < 7);
        1: bus.out_ready = 1'b1;
        default: bus.out_ready = 1'b0;
      endcase
    end
  end

  // Cycle-by-cycle comparison against the expected-result queue
  always @(negedge clk) begin
    exp_t e;
    bit exp_ov, exp_busy, exp_ir;
    if (chk_en && !rst) begin
      exp_ov   = (q.size() > 0) && (cyc >= q[0].due);
      exp_busy = (q.size() > 0) && (cyc < q[0].due);
      exp_ir   = !exp_busy && (!exp_ov || bus.out_ready);
      check("out_valid", bus.out_valid, exp_ov);
      check("busy", bus.busy, exp_busy);
      check("in_ready", bus.in_ready, exp_ir);
      if (exp_ov && bus.out_valid) begin
        check("result", bus.result, q[0].res);
        check("zero_flag", bus.zero_flag, q[0].z);
        check("neg_flag", bus.neg_flag, q[0].n);
        check("carry_flag", bus.carry_flag, q[0].c);
        check("ovf_flag", bus.ovf_flag, q[0].v);
        check("illegal_op", bus.illegal_op, q[0].ill);
      end
      if (exp_ov && bus.out_ready) void'(q.pop_front());
      if (bus.in_valid && bus.in_ready) begin
        e = model(bus.alu_op, bus.operand1, bus.operand2);
        e.due = cyc + ((bus.alu_op == 4'd13) ? (W + 1) : 1);
        q.push_back(e);
      end
    end
  end

  task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    bit ok;
    ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.alu_op   = op;
    bus.operand1 = a;
    bus.operand2 = b;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("accept_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 200; i++) begin
      if (q.size() == 0) break;
      @(posedge clk);
      #1;
    end
    check(name, q.size(), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_out_valid"}, bus.out_valid, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_in_ready"}, bus.in_ready, 0);
    check({tag, "_result"}, bus.result, 0);
    check({tag, "_flags"}, {bus.zero_flag, bus.neg_flag, bus.carry_flag, bus.ovf_flag}, 0);
    check({tag, "_illegal"}, bus.illegal_op, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t m;
    int nbusy;

    bus.in_valid = 1'b0; bus.alu_op = 4'd0; bus.operand1 = '0; bus.operand2 = '0;
    bus0.in_valid = 1'b0; bus0.alu_op = 4'd0; bus0.operand1 = '0; bus0.operand2 = '0;
    bus0.out_ready = 1'b1;

    // Pin the model with hand-computed values
    m = model(4'd0, 32'hFFFF_FFFF, 32'h1);
    check("pin_add_wrap", {m.res, m.z, m.c, m.v}, {32'h0, 1'b1, 1'b1, 1'b0});
    m = model(4'd0, 32'h7FFF_FFFF, 32'h1);
    check("pin_add_ovf", {m.res, m.n, m.v, m.c}, {32'h8000_0000, 1'b1, 1'b1, 1'b0});
    m = model(4'd1, 32'd3, 32'd5);
    check("pin_sub_borrow", {m.res, m.c, m.n}, {32'hFFFF_FFFE, 1'b1, 1'b1});
    m = model(4'd10, 32'h8000_0000, 32'd31);
    check("pin_sra", m.res, 32'hFFFF_FFFF);
    m = model(4'd8, 32'h1, 32'h25);
    check("pin_sll", m.res, 32'h20);
    m = model(4'd11, 32'hFFFF_FFFF, 32'h1);
    check("pin_slt", m.res, 32'h1);
    m = model(4'd12, 32'hFFFF_FFFF, 32'h1);
    check("pin_sltu", m.res, 32'h0);
    m = model(4'd13, 32'h1_0000, 32'h1_0000);
    check("pin_mul", {m.res, m.c, m.z}, {32'h0, 1'b1, 1'b1});
    m = model(4'd14, 32'h1234, 32'h5678);
    check("pin_illegal", {m.res, m.z, m.ill}, {32'h0, 1'b1, 1'b1});

    // Reset state
    #1 rst = 1'b1;
    #1 check_all_zero("reset");
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;

    // Directed single-cycle ops, back to back
    ordy_mode = 1;
    send(4'd0, 32'hFFFF_FFFF, 32'h1);
    send(4'd0, 32'h7FFF_FFFF, 32'h1);
    send(4'd1, 32'd3, 32'd5);
    send(4'd10, 32'h8000_0000, 32'd31);
    send(4'd8, 32'h1, 32'h25);
    send(4'd11, 32'hFFFF_FFFF, 32'h1);
    send(4'd12, 32'hFFFF_FFFF, 32'h1);
    send(4'd14, 32'hDEAD_BEEF, 32'h1);
    send(4'd15, 32'h0, 32'h0);

    // Multiply: busy window and latency
    send(4'd13, 32'h1_0000, 32'h1_0000);
    nbusy = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.busy) nbusy++;
      else break;
    end
    check("mul_busy_cycles", nbusy, W);
    check("mul_latency_valid", bus.out_valid, 1);
    send(4'd13, 32'd7, 32'd9);
    drain("drain_directed");

    // Multiplier disabled: MUL is illegal and single-cycle
    @(posedge clk); #1;
    bus0.in_valid = 1'b1; bus0.alu_op = 4'd13;
    bus0.operand1 = 32'h1_0000; bus0.operand2 = 32'h1_0000;
    @(negedge clk);
    check("nomul_in_ready", bus0.in_ready, 1);
    @(posedge clk); #1;
    bus0.in_valid = 1'b0;
    @(negedge clk);
    check("nomul_out_valid", bus0.out_valid, 1);
    check("nomul_illegal", bus0.illegal_op, 1);
    check("nomul_result", bus0.result, 0);
    check("nomul_flags", {bus0.zero_flag, bus0.neg_flag, bus0.carry_flag, bus0.ovf_flag}, 4'b1000);
    check("nomul_busy", bus0.busy, 0);

    // Output stall: result held, new op waits, then accepted on release
    ordy_mode = 2;
    @(posedge clk); #1;
    send(4'd0, 32'd5, 32'd6);
    bus.in_valid = 1'b1; bus.alu_op = 4'd4;
    bus.operand1 = 32'h0000_F0F0; bus.operand2 = 32'h0000_FF00;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_in_ready", bus.in_ready, 0);
      check("stall_result", bus.result, 32'd11);
      bus.operand1 = $urandom;
    end
    bus.operand1 = 32'h0000_F0F0;
    ordy_mode = 1;
    @(posedge clk); #2;
    @(negedge clk);
    check("release_in_ready", bus.in_ready, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("release_out_valid", bus.out_valid, 1);
    check("release_result", bus.result, 32'h0000_0FF0);
    drain("drain_stall");

    // Randomised traffic
    ordy_mode = 0;
    for (int k = 0; k < 300; k++) begin
      logic [3:0] op;
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      op = ($urandom_range(0, 9) == 0) ? 4'd13 : 4'($urandom_range(0, 15));
      send(op, pick(), pick());
    end
    ordy_mode = 1;
    drain("drain_random");

    // Reset in the middle of a multiply
    @(posedge clk); #1;
    send(4'd13, 32'd7, 32'd9);
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    chk_en = 1'b0;
    q.delete();
    #1 check_all_zero("midmul_reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    check("post_reset_in_ready", bus.in_ready, 1);
    check("post_reset_out_valid", bus.out_valid, 0);
    repeat (40) @(posedge clk);
    #1;
    check("post_reset_no_stale", bus.out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
